// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg : active-low 7-segment glyph constants and nibble type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  typedef logic [3:0] nibble_t;

  // All segments dark; also the idle value of the segment input register
  localparam logic [6:0] c_blank = 7'h7F;

  // Index = hex digit; each entry is seg[0:6] packed with seg[0] (segment a) as MSB
  localparam logic [6:0] c_glyph [0:15] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

`default_nettype wire

// File: rtl/seg7_to_hex.sv
// ---------------------------------------------------------------------------
// seg7_to_hex : combinational active-low glyph to hex nibble decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_glyph,
  output nibble_t    o_nibble,
  output logic       o_hit
);

  always_comb begin
    o_nibble = '0;
    o_hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_glyph == c_glyph[i]) begin
        o_nibble = nibble_t'(i);
        o_hit    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_capture.sv
// ---------------------------------------------------------------------------
// seg_scan_capture : recovers hex digits from a multiplexed 7-segment bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_scan_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS-1:0]     an,
  input  logic [0:6]            seg,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  err,
  output logic [2:0]            err_digit
);

  localparam logic [7:0] c_stable = 8'(STABLE);

  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_prev_an;
  logic [6:0]          r_prev_seg;
  logic [7:0]          r_cnt;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_valid;
  logic                r_frame;
  logic                r_err;
  logic [2:0]          r_err_digit;

  logic [DIGITS-1:0]   w_sel;
  logic                w_onehot;
  logic                w_changed;
  logic [7:0]          w_cnt_nxt;
  logic                w_cap;
  logic [2:0]          w_idx;
  nibble_t             w_nibble;
  logic                w_hit;

  seg7_to_hex u_dec (
    .i_glyph  (r_seg),
    .o_nibble (w_nibble),
    .o_hit    (w_hit)
  );

  assign w_sel     = ~r_an;
  assign w_onehot  = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
  assign w_changed = {r_an, r_seg} != {r_prev_an, r_prev_seg};

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!w_onehot)              w_cnt_nxt = 8'd0;
    else if (w_changed)         w_cnt_nxt = 8'd1;
    else if (r_cnt < c_stable)  w_cnt_nxt = r_cnt + 8'd1;
  end

  // Fire only on the transition into STABLE so a held pattern captures once
  assign w_cap = w_onehot && (w_changed ? (c_stable == 8'd1)
                                        : (r_cnt == c_stable - 8'd1));

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_sel[i]) w_idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an        <= '1;
      r_seg       <= c_blank;
      r_prev_an   <= '1;
      r_prev_seg  <= c_blank;
      r_cnt       <= '0;
      r_seen      <= '0;
      r_value     <= '0;
      r_valid     <= '0;
      r_frame     <= 1'b0;
      r_err       <= 1'b0;
      r_err_digit <= '0;
    end else begin
      r_an       <= an;
      r_seg      <= seg;
      r_prev_an  <= r_an;
      r_prev_seg <= r_seg;
      r_cnt      <= w_cnt_nxt;
      r_frame    <= 1'b0;
      r_err      <= 1'b0;
      if (w_cap) begin
        if (w_hit) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (w_sel[i]) r_value[4*i +: 4] <= w_nibble;
          end
          r_valid <= r_valid | w_sel;
          if ((r_seen | w_sel) == {DIGITS{1'b1}}) begin
            r_frame <= 1'b1;
            r_seen  <= '0;
          end else begin
            r_seen  <= r_seen | w_sel;
          end
        end else begin
          r_err       <= 1'b1;
          r_err_digit <= w_idx;
          r_valid     <= r_valid & ~w_sel;
        end
      end
    end
  end

  assign value       = r_value;
  assign digit_valid = r_valid;
  assign frame_valid = r_frame;
  assign err         = r_err;
  assign err_digit   = r_err_digit;

endmodule

`default_nettype wire
